// File: rtl/instr_queue_pkg.sv
// ============================================================================
// instr_queue_pkg : shared fetch/decode widths and the queue entry record
// Rev 1.0
// ============================================================================
`default_nettype none

package instr_queue_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } iq_entry_t;

endpackage

`default_nettype wire

// File: rtl/instr_queue_if.sv
// ============================================================================
// instr_queue_if : fetch-side push, decode-side pop, flush and occupancy
// Rev 1.0
// ============================================================================
`default_nettype none

interface instr_queue_if #(
  parameter int XLEN  = instr_queue_pkg::XLEN,
  parameter int DEPTH = 4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                                ifu_instrValid;
  logic [instr_queue_pkg::INSTR_W-1:0] ifu_instr;
  logic [XLEN-1:0]                     ifu_pc;
  logic                                ifu_ready;
  logic                                idu_valid;
  logic [instr_queue_pkg::INSTR_W-1:0] idu_instr;
  logic [XLEN-1:0]                     idu_pc;
  logic                                idu_ready;
  logic                                flush;
  logic [CNT_W-1:0]                    count;

  modport master (
    output ifu_instrValid, ifu_instr, ifu_pc, idu_ready, flush,
    input  ifu_ready, idu_valid, idu_instr, idu_pc, count
  );

  modport slave (
    input  ifu_instrValid, ifu_instr, ifu_pc, idu_ready, flush,
    output ifu_ready, idu_valid, idu_instr, idu_pc, count
  );

endinterface

`default_nettype wire

// File: rtl/instr_queue_sync_fifo.sv
// ============================================================================
// sync_fifo : generic circular FIFO with occupancy counter and sync clear
// Rev 1.0
// ============================================================================
`default_nettype none

module dff_en #(
  parameter int WIDTH = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             en,
  input  wire logic [WIDTH-1:0] d,
  output logic      [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     clr,
  input  wire logic                     push,
  input  wire logic                     pop,
  input  wire logic [WIDTH-1:0]         wdata,
  output logic      [WIDTH-1:0]         rdata,
  output logic                          full,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   count
);

  import instr_queue_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW-1:0]    w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             w_push, w_pop;
  logic             w_wr_en, w_rd_en, w_cnt_en;

  assign full  = (r_cnt == CW'(DEPTH));
  assign empty = (r_cnt == '0);
  assign count = r_cnt;
  assign rdata = r_mem[r_rd_ptr];

  // Clear wins over any same-cycle push or pop.
  assign w_push = push & ~full  & ~clr;
  assign w_pop  = pop  & ~empty & ~clr;

  assign w_wr_en  = clr | w_push;
  assign w_rd_en  = clr | w_pop;
  assign w_cnt_en = clr | (w_push ^ w_pop);

  always_comb begin
    w_wr_ptr_nxt = clr ? '0 : r_wr_ptr + 1'b1;
    w_rd_ptr_nxt = clr ? '0 : r_rd_ptr + 1'b1;
    w_cnt_nxt    = r_cnt;
    if (clr)
      w_cnt_nxt = '0;
    else if (w_push)
      w_cnt_nxt = r_cnt + 1'b1;
    else
      w_cnt_nxt = r_cnt - 1'b1;
  end

  dff_en #(.WIDTH(AW)) u_wr_ptr (.clk(clk), .rst(rst), .en(w_wr_en),  .d(w_wr_ptr_nxt), .q(r_wr_ptr));
  dff_en #(.WIDTH(AW)) u_rd_ptr (.clk(clk), .rst(rst), .en(w_rd_en),  .d(w_rd_ptr_nxt), .q(r_rd_ptr));
  dff_en #(.WIDTH(CW)) u_cnt    (.clk(clk), .rst(rst), .en(w_cnt_en), .d(w_cnt_nxt),    .q(r_cnt));

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/instr_queue.sv
// ============================================================================
// instr_queue : fetch-to-decode instruction buffer with flush
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int XLEN  = instr_queue_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  instr_queue_if.slave  bus
);

  localparam int ENTRY_W = INSTR_W + XLEN;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic               w_push, w_pop, w_full, w_empty;
  logic [ENTRY_W-1:0] w_wdata, w_rdata;
  logic [CNT_W-1:0]   w_count;

  // Ready and valid decode only from registered occupancy, never from idu_ready.
  assign bus.ifu_ready = ~w_full;
  assign bus.idu_valid = ~w_empty;
  assign bus.count     = w_count;

  assign w_push  = bus.ifu_instrValid & ~w_full  & ~bus.flush;
  assign w_pop   = bus.idu_ready      & ~w_empty & ~bus.flush;
  assign w_wdata = {bus.ifu_instr, bus.ifu_pc};
  assign {bus.idu_instr, bus.idu_pc} = w_rdata;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.flush),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_queue.sv
// ============================================================================
// tb_instr_queue : directed scenarios plus random traffic vs a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_queue;

  import instr_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  instr_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  instr_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  iq_entry_t model_q[$];
  int        n_checks = 0;
  int        n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_count"}, 128'(bus.count), 128'(model_q.size()));
    check({tag, "_valid"}, 128'(bus.idu_valid), 128'(model_q.size() != 0));
    check({tag, "_ready"}, 128'(bus.ifu_ready), 128'(model_q.size() != DEPTH));
    if (model_q.size() != 0) begin
      check({tag, "_instr"}, 128'(bus.idu_instr), 128'(model_q[0].instr));
      check({tag, "_pc"},    128'(bus.idu_pc),    128'(model_q[0].pc));
    end
  endtask

  // One clock: apply inputs, advance the model on the edge, compare 1 ns later.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc_v,
                      input logic rdy, input logic fl, input string tag);
    bit m_ready, m_valid;
    bus.ifu_instrValid = v;
    bus.ifu_instr      = ins;
    bus.ifu_pc         = pc_v;
    bus.idu_ready      = rdy;
    bus.flush          = fl;
    m_ready = (model_q.size() < DEPTH);
    m_valid = (model_q.size() > 0);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (m_valid && rdy)
        void'(model_q.pop_front());
      if (v && m_ready)
        model_q.push_back('{instr: ins, pc: pc_v});
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    bus.ifu_instrValid = 1'b0;
    bus.ifu_instr      = '0;
    bus.ifu_pc         = '0;
    bus.idu_ready      = 1'b0;
    bus.flush          = 1'b0;

    #12;
    check("rst_count", 128'(bus.count), 128'd0);
    check("rst_valid", 128'(bus.idu_valid), 128'd0);
    check("rst_ready", 128'(bus.ifu_ready), 128'd1);
    @(negedge clk);
    rst = 1'b1;

    // Fill to DEPTH with decode stalled
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h0000_0013 + 32'(i), 64'h8000_0000 + 64'(4 * i), 1'b0, 1'b0, "fill");
    check("fill_count", 128'(bus.count), 128'd4);
    check("fill_ready", 128'(bus.ifu_ready), 128'd0);
    check("fill_head_pc", 128'(bus.idu_pc), 128'h8000_0000);

    step(1'b1, 32'h0000_0099, 64'h8000_0010, 1'b0, 1'b0, "full_ignore");
    check("full_ignore_count", 128'(bus.count), 128'd4);

    // Full with a simultaneous pop: only the pop takes effect
    step(1'b1, 32'h0000_0099, 64'h8000_0010, 1'b1, 1'b0, "full_pop");
    check("full_pop_count", 128'(bus.count), 128'd3);
    check("full_pop_ready", 128'(bus.ifu_ready), 128'd1);
    check("full_pop_head", 128'(bus.idu_pc), 128'h8000_0004);
    step(1'b1, 32'h0000_0099, 64'h8000_0010, 1'b0, 1'b0, "retry");
    check("retry_count", 128'(bus.count), 128'd4);

    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, "flush_full");

    // Streaming: head is always the word pushed on the previous edge
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h0000_1000 + 32'(i), 64'h1000 + 64'(4 * i), 1'b1, 1'b0, "stream");
      check("stream_count", 128'(bus.count), 128'd1);
      check("stream_head", 128'(bus.idu_instr), 128'h1000 + 128'(i));
    end
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, "drain");

    // Ten push/pop pairs cross the pointer wrap point twice
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h0000_00A0 + 32'(i), 64'h2000 + 64'(4 * i), 1'b1, 1'b0, "wrap");
      check("wrap_head", 128'(bus.idu_instr), 128'hA0 + 128'(i));
    end
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, "drain2");

    // Flush with three entries and a same-cycle push
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h0000_0300 + 32'(i), 64'h3000 + 64'(4 * i), 1'b0, 1'b0, "pre_flush");
    step(1'b1, 32'h0000_0333, 64'h3333, 1'b1, 1'b1, "flush");
    check("flush_count", 128'(bus.count), 128'd0);
    check("flush_valid", 128'(bus.idu_valid), 128'd0);
    check("flush_ready", 128'(bus.ifu_ready), 128'd1);
    step(1'b1, 32'h0000_BEEF, 64'h4000, 1'b0, 1'b0, "post_flush");
    check("post_flush_head", 128'(bus.idu_instr), 128'hBEEF);

    // Asynchronous reset between edges with two entries queued
    step(1'b1, 32'h0000_CAFE, 64'h4004, 1'b0, 1'b0, "pre_arst");
    bus.ifu_instrValid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", 128'(bus.count), 128'd0);
    check("arst_valid", 128'(bus.idu_valid), 128'd0);
    check("arst_ready", 128'(bus.ifu_ready), 128'd1);
    model_q.delete();
    @(negedge clk);
    rst = 1'b1;

    // Random traffic with shifting decode pressure
    for (int i = 0; i < 400; i++) begin
      logic rv, rr, rf;
      rv = ($urandom_range(0, 3) != 0);
      rr = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rf = ($urandom_range(0, 31) == 0);
      step(rv, $urandom, {$urandom, $urandom}, rr, rf, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_queue.md
# instr_queue

Instruction queue between the fetch unit and the decode stage. It captures each fetched instruction word with its PC when fetch signals valid, and buffers up to DEPTH entries in a circular FIFO. It presents the oldest entry to decode over a valid/ready handshake. It backpressures fetch when full and discards all contents on a pipeline flush.

## Interface
- `XLEN`, default 64: PC width in bits.
- `DEPTH`, default 4: number of entries; must be a power of two and at least 2.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ifu_instrValid` in 1: fetch presents a valid instruction this cycle.
- `ifu_instr` in 32: fetched instruction word.
- `ifu_pc` in XLEN: PC of `ifu_instr`.
- `ifu_ready` out 1: queue accepts a push this cycle; fetch holds its PC while this is low.
- `idu_valid` out 1: head entry is valid.
- `idu_instr` out 32: head instruction word.
- `idu_pc` out XLEN: head PC.
- `idu_ready` in 1: decode consumes the head this cycle.
- `flush` in 1: redirect or exception; empty the queue.
- `count` out $clog2(DEPTH)+1: current occupancy.

## Operation
- Storage: DEPTH entries, each holding {instr[31:0], pc[XLEN-1:0]}.
- Pointers: `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is a separate counter `cnt` in the range 0..DEPTH.
- Push = `ifu_instrValid & ifu_ready & ~flush`. On push, write the entry at `wr_ptr` and increment `wr_ptr`.
- Pop = `idu_valid & idu_ready & ~flush`. On pop, increment `rd_ptr`.
- `cnt` update: +1 on push only, -1 on pop only, unchanged when push and pop occur together.
- `ifu_ready = (cnt != DEPTH)`. This is decoded from registered state only and has no combinational path from `idu_ready`. When the queue is full, a same-cycle pop does not permit a push.
- `idu_valid = (cnt != 0)`. `idu_instr` and `idu_pc` come from the entry at `rd_ptr`. Their values are don't-care while `idu_valid` is low.
- No bypass path: a pushed entry first appears at the head on the cycle after the push.
- Flush has priority over everything else. On the next edge, `wr_ptr`, `rd_ptr` and `cnt` all become 0. Any same-cycle push and pop are dropped, and storage contents are left stale.
- `count = cnt`.

## Timing
- Reset, asynchronous and active-low: pointers and `cnt` go to 0. This gives `idu_valid=0`, `ifu_ready=1`, `count=0`. Storage is not reset.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency from fetch input to decode output is 1 cycle. Sustained throughput is 1 instruction per cycle whenever `0 < cnt < DEPTH`.
- Empty with a push: `idu_valid` rises the next cycle. Empty with `idu_ready=1` and no push: no change.
- Full (`cnt=DEPTH`): `ifu_ready=0` and `ifu_instrValid` is ignored. A pop drops `cnt` to DEPTH-1, and `ifu_ready` rises the next cycle.
- Both pointers wrap from DEPTH-1 to 0 without a bubble.
- Flush with `ifu_instrValid=1` in the same cycle: the instruction is lost. After the edge the queue is empty with `ifu_ready=1`.
- The head output registers hold stable while `idu_valid & ~idu_ready`.

## Structure
- Shared package holds:
  - `XLEN`, with the same value used by fetch and decode.
  - A typedef for the entry record {instr, pc}.
  - The `INSTR_W=32` constant.
- One natural sub-module, `sync_fifo`:
  - Generic data width and depth.
  - Push and pop ports, plus full, empty and count outputs, with a synchronous clear.
  - `instr_queue` wraps it and adds the fetch/decode port naming and flush gating.
- Pointer and count registers use the codebase's resettable register primitive with enable. Storage uses plain flops without reset.

## Test plan
- Reset and fill: release `rst`, push PCs 0x80000000, 0x80000004, 0x80000008, 0x8000000C with `idu_ready=0`.
  - `count` goes to 4 and `ifu_ready` falls after the 4th push.
  - A 5th valid instruction is not accepted.
  - The head shows PC 0x80000000.
- Streaming: with `idu_ready=1` and a continuous push, instructions exit in order exactly one cycle after entry. `count` stays at 1 and the queue never stalls.
- Full with a simultaneous pop: hold full, pulse `idu_ready` once with `ifu_instrValid=1`.
  - In that cycle only the pop occurs and `count` goes to 3.
  - `ifu_ready` rises next cycle, and the retried instruction is accepted.
- Wrap-around: perform 10 push/pop pairs with DEPTH=4. Instructions 0xA0..0xA9 exit in order and the pointers cross index 3→0 twice.
- Flush with 3 entries plus a same-cycle push: next cycle `count=0`, `idu_valid=0`, `ifu_ready=1`. The next push is the next entry seen at the head.
- Asynchronous reset mid-stream: drop `rst` between clock edges with 2 entries queued. `idu_valid` goes to 0 and `count` to 0 without a clock edge.
